// File: rtl/oled_axil_slave_regs_if.sv
// AXI4-Lite register bus between the master (PS or bench VIP) and the OLED register slave.
`timescale 1ns/1ps
interface oled_axil_slave_regs_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/oled_axil_slave_regs.sv
// AXI4-Lite slave: four R/W control registers, a read-only status word and the
// SPI engine start pulse. Write and read channels run as independent FSMs.
`timescale 1ns/1ps
module oled_axil_slave_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    oled_axil_slave_regs_if.slave         s_axi,
    input  logic                          busy_i,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic                          start_pulse_o
);
    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W    = AW - 2;
    localparam int unsigned STRB_W   = DW / 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned STAT_IDX = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e                     w_state_q, w_state_d;
    r_state_e                     r_state_q, r_state_d;
    logic [NUM_REGS-1:0][DW-1:0]  regs_q, regs_d;
    logic                         aw_full_q, aw_full_d;
    logic                         w_full_q, w_full_d;
    logic [IDX_W-1:0]             awidx_q, awidx_d;
    logic [DW-1:0]                wdata_q, wdata_d;
    logic [STRB_W-1:0]            wstrb_q, wstrb_d;
    logic                         awready_q, awready_d;
    logic                         wready_q, wready_d;
    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic                         start_q, start_d;
    logic                         arready_q, arready_d;
    logic                         rvalid_q, rvalid_d;
    logic [DW-1:0]                rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;

    logic                         aw_hs_c, w_hs_c, ar_hs_c;
    logic [IDX_W-1:0]             cmt_idx_c, rd_idx_c;
    logic [DW-1:0]                cmt_data_c;
    logic [STRB_W-1:0]            cmt_strb_c;
    logic                         unused_c;

    assign unused_c = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign aw_hs_c = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs_c  = s_axi.S_AXI_WVALID & wready_q;
    assign ar_hs_c = s_axi.S_AXI_ARVALID & arready_q;

    // A beat handshaking this cycle commits straight from the bus; an earlier beat comes from its latch.
    assign cmt_idx_c  = aw_full_q ? awidx_q : s_axi.S_AXI_AWADDR[AW-1:2];
    assign cmt_data_c = w_full_q  ? wdata_q : s_axi.S_AXI_WDATA;
    assign cmt_strb_c = w_full_q  ? wstrb_q : s_axi.S_AXI_WSTRB;
    assign rd_idx_c   = s_axi.S_AXI_ARADDR[AW-1:2];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            regs_q    <= '0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            start_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            start_q   <= start_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Write channel: collect AW and W in any order, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        regs_d    = regs_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        start_d   = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_full_d = 1'b1;
                    awidx_d   = s_axi.S_AXI_AWADDR[AW-1:2];
                end
                if (w_hs_c) begin
                    w_full_d = 1'b1;
                    wdata_d  = s_axi.S_AXI_WDATA;
                    wstrb_d  = s_axi.S_AXI_WSTRB;
                end
                if ((aw_full_q | aw_hs_c) && (w_full_q | w_hs_c)) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (cmt_idx_c < IDX_W'(NUM_REGS)) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (cmt_strb_c[b]) begin
                                regs_d[cmt_idx_c[1:0]][8*b +: 8] = cmt_data_c[8*b +: 8];
                            end
                        end
                        bresp_d = RESP_OKAY;
                        start_d = (cmt_idx_c == '0) & cmt_strb_c[0] & cmt_data_c[0];
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    awready_d = ~(aw_full_q | aw_hs_c);
                    wready_d  = ~(w_full_q | w_hs_c);
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // Read channel: sample registers at the AR handshake (pre-write on a same-cycle commit).
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_c) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    if (rd_idx_c < IDX_W'(NUM_REGS)) begin
                        rdata_d = regs_q[rd_idx_c[1:0]];
                        rresp_d = RESP_OKAY;
                    end else if (rd_idx_c == IDX_W'(STAT_IDX)) begin
                        rdata_d = {(DW-1)'(0), busy_i};
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign reg0_o        = regs_q[0];
    assign reg1_o        = regs_q[1];
    assign reg2_o        = regs_q[2];
    assign reg3_o        = regs_q[3];
    assign start_pulse_o = start_q;
endmodule

// File: tb/tb_oled_axil_slave_regs.sv
// Directed plus randomized bench for oled_axil_slave_regs against an address-map model.
`timescale 1ns/1ps
module tb_oled_axil_slave_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy = 1'b0;
    logic [31:0] r0, r1, r2, r3;
    logic        sp;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [4];

    always #5 clk = ~clk;

    oled_axil_slave_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    oled_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(clk), .ARESET(rst), .s_axi(bus), .busy_i(busy),
        .reg0_o(r0), .reg1_o(r1), .reg2_o(r2), .reg3_o(r3), .start_pulse_o(sp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_reg0"}, r0, mdl[0]);
        chk({tag, "_reg1"}, r1, mdl[1]);
        chk({tag, "_reg2"}, r2, mdl[2]);
        chk({tag, "_reg3"}, r3, mdl[3]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, bus.S_AXI_AWREADY, 0);
        chk({tag, "_wready"},  bus.S_AXI_WREADY, 0);
        chk({tag, "_arready"}, bus.S_AXI_ARREADY, 0);
        chk({tag, "_bvalid"},  bus.S_AXI_BVALID, 0);
        chk({tag, "_rvalid"},  bus.S_AXI_RVALID, 0);
        chk({tag, "_bresp"},   bus.S_AXI_BRESP, 0);
        chk({tag, "_rresp"},   bus.S_AXI_RRESP, 0);
        chk({tag, "_rdata"},   bus.S_AXI_RDATA, 0);
        chk({tag, "_start"},   sp, 0);
        chk_regs(tag);
    endtask

    // Reference: word address >= 4 is not writable; each set strobe bit replaces one byte.
    task automatic mdl_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic pulse);
        int w;
        w = int'(addr) / 4;
        pulse = 1'b0;
        if (w >= 4) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[w][8*k +: 8] = d[8*k +: 8];
            pulse = (w == 0) && s[0] && d[0];
        end
    endtask

    task automatic mdl_read(input logic [4:0] addr, input logic b,
                            output logic [31:0] d, output logic [1:0] resp);
        int w;
        w = int'(addr) / 4;
        resp = 2'b00;
        if (w < 4)       d = mdl[w];
        else if (w == 4) d = {31'd0, b};
        else begin d = 32'd0; resp = 2'b10; end
    endtask

    // Drive one write; AW and W each appear after their own delay (in cycles).
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        logic [1:0] eresp;
        logic       epulse;
        bit         aw_done, w_done, aw_hs, w_hs;
        aw_done = 0; w_done = 0;
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_AWPROT = 3'($urandom);
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_BREADY = 1'b1;
        for (int cyc = 0; cyc < 64 && !(aw_done && w_done); cyc++) begin
            bus.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            bus.S_AXI_WVALID  = !w_done && cyc >= w_dly;
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            if (!(aw_done && w_done)) chk("bvalid_before_commit", bus.S_AXI_BVALID, 0);
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        checks++;
        assert (aw_done && w_done) else begin
            errors++;
            $error("FAIL write_handshake_timeout: aw_done %0d w_done %0d required 1 1", aw_done, w_done);
            return;
        end
        mdl_write(addr, data, strb, eresp, epulse);
        chk("bvalid_after_commit", bus.S_AXI_BVALID, 1);
        chk("bresp", bus.S_AXI_BRESP, eresp);
        chk("start_pulse", sp, epulse);
        chk_regs("write");
        @(posedge clk); #1;
        chk("bvalid_cleared", bus.S_AXI_BVALID, 0);
        chk("start_pulse_single", sp, 0);
        chk("awready_reopen", bus.S_AXI_AWREADY, 1);
        chk("wready_reopen", bus.S_AXI_WREADY, 1);
    endtask

    task automatic axi_read(input logic [4:0] addr);
        logic [31:0] ed;
        logic [1:0]  er;
        bit          hs;
        hs = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_RREADY  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        for (int cyc = 0; cyc < 64 && !hs; cyc++) begin
            hs = bus.S_AXI_ARREADY;
            @(posedge clk); #1;
        end
        bus.S_AXI_ARVALID = 1'b0;
        checks++;
        assert (hs) else begin
            errors++;
            $error("FAIL read_handshake_timeout: arready 0 required 1");
            return;
        end
        mdl_read(addr, busy, ed, er);
        chk("rvalid", bus.S_AXI_RVALID, 1);
        chk("rdata", bus.S_AXI_RDATA, ed);
        chk("rresp", bus.S_AXI_RRESP, er);
        @(posedge clk); #1;
        chk("rvalid_cleared", bus.S_AXI_RVALID, 0);
        chk("arready_reopen", bus.S_AXI_ARREADY, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rd, wd;
        logic [1:0]  er;
        logic        ep;
        for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        // Reset values, then READYs on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("awready_after_reset", bus.S_AXI_AWREADY, 1);
        chk("wready_after_reset",  bus.S_AXI_WREADY, 1);
        chk("arready_after_reset", bus.S_AXI_ARREADY, 1);

        // Sequential writes and readback.
        for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(5'(4 * i));

        // W three cycles ahead of AW.
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0);
        chk("reg2_deadbeef", r2, 32'hDEADBEEF);

        // Byte strobes.
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_write(5'h04, 32'h12345678, 4'b0101, 0, 1);
        chk("reg1_strobed", r1, 32'hFF34FF78);
        axi_read(5'h04);
        axi_write(5'h0C, 32'hA5A5A5A5, 4'h0, 1, 0);

        // Non-writable addresses and status read.
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_write(5'h18, 32'hFFFFFFFF, 4'hF, 0, 2);
        axi_read(5'h18);
        busy = 1'b1;
        axi_read(5'h10);
        busy = 1'b0;
        axi_read(5'h10);

        // Start pulse qualifiers.
        axi_write(5'h00, 32'h1, 4'hF, 0, 0);
        axi_write(5'h00, 32'h0, 4'hF, 0, 0);
        axi_write(5'h00, 32'h1, 4'b1110, 0, 0);
        axi_write(5'h00, 32'h3, 4'b0001, 2, 2);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            logic [4:0] a;
            a = {3'($urandom_range(0, 7)), 2'($urandom)};
            busy = 1'($urandom);
            if ($urandom_range(0, 2) != 0)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a);
        end

        // Stalled responses with a same-cycle write and read of REG3, then reset mid-stall.
        wd = 32'hC0FFEE11;
        exp_rd = mdl[3];
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_WDATA = wd; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 5'h0C;
        chk("stall_pre_awready", bus.S_AXI_AWREADY, 1);
        chk("stall_pre_wready",  bus.S_AXI_WREADY, 1);
        chk("stall_pre_arready", bus.S_AXI_ARREADY, 1);
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        mdl_write(5'h0C, wd, 4'hF, er, ep);
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_ARADDR = 5'h04;
        for (int c = 0; c < 10; c++) begin
            chk("stall_bvalid",  bus.S_AXI_BVALID, 1);
            chk("stall_bresp",   bus.S_AXI_BRESP, er);
            chk("stall_rvalid",  bus.S_AXI_RVALID, 1);
            chk("stall_rdata",   bus.S_AXI_RDATA, exp_rd);
            chk("stall_awready", bus.S_AXI_AWREADY, 0);
            chk("stall_arready", bus.S_AXI_ARREADY, 0);
            @(posedge clk); #1;
        end
        chk_regs("stall");
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
        chk_reset_outputs("midreset");
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;  bus.S_AXI_RREADY = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_bvalid", bus.S_AXI_BVALID, 0);
        for (int i = 0; i < 4; i++) axi_read(5'(4 * i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
